// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 ("double dabble") binary-to-BCD converter.
// One iteration per clock under a start/busy/done handshake; the result is registered.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + WIDTH;

  // Too few digits would let the largest input overflow the digit field.
  if (!(longint'(10) ** DIGITS > (longint'(1) << WIDTH) - 1)) begin : g_digits_too_small
    $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [BCD_W-1:0]  digits_q, digits_d;
  logic [BCD_W-1:0]  digitsAdj;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [WIDTH-1:0]  binSh_q, binSh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SR_W-1:0]   shifted;

  always_comb begin
    digitsAdj = digits_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (digits_q[4*i +: 4] > 4'd4) begin
        digitsAdj[4*i +: 4] = digits_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign shifted = {digitsAdj, binSh_q} << 1;

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    binSh_d  = binSh_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    unique case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new start exactly like IDLE so back-to-back runs lose no cycle.
        if (start) begin
          binSh_d  = bin;
          digits_d = '0;
          cnt_d    = CNT_W'(WIDTH);
          state_d  = SHIFT;
        end else begin
          state_d  = IDLE;
        end
      end
      SHIFT: begin
        digits_d = shifted[SR_W-1:WIDTH];
        binSh_d  = shifted[WIDTH-1:0];
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = shifted[SR_W-1:WIDTH];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      digits_q <= '0;
      binSh_q  <= '0;
      cnt_q    <= '0;
      bcd_q    <= '0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      binSh_q  <= binSh_d;
      cnt_q    <= cnt_d;
      bcd_q    <= bcd_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign bcd  = bcd_q;

endmodule
